// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch-capable CPU control FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package branch_ctrl_pkg;

  // Controller states; any other encoding is treated as illegal and recovers to S_FETCH.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4,
    S_BX     = 3'd5
  } state_t;

  // PC source select driven back to the fetch unit; 2'b11 is never produced.
  typedef logic [1:0] pc_sel_t;
  localparam pc_sel_t PCS_INC = 2'b00;
  localparam pc_sel_t PCS_B   = 2'b01;
  localparam pc_sel_t PCS_REG = 2'b10;

  // ARM bits [27:4] of BX Rm.
  localparam logic [23:0] BX_PATTERN = 24'h12FFF1;

  // Top two opcode bits of TST/TEQ/CMP/CMN.
  localparam logic [1:0] TEST_OP_MASK = 2'b10;

endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch/branch datapath <-> control FSM signal bundle.
// Latency: n/a (wires only).
// Backpressure: none; master drives controls, slave drives flag and IR.
interface branch_ctrl_if;
  import branch_ctrl_pkg::*;

  logic        flag;
  logic [28:1] IR;
  logic        Write_IR;
  logic        Write_PC;
  pc_sel_t     PC_s;
  logic        Write_Reg;
  logic        rd_s;
  logic        Write_PSR;
  logic [3:0]  ALU_OP;
  logic        alu_src;
  logic        Write_Res;
  logic        undef;

  modport master (
    input  flag, IR,
    output Write_IR, Write_PC, PC_s, Write_Reg, rd_s, Write_PSR,
           ALU_OP, alu_src, Write_Res, undef
  );

  modport slave (
    output flag, IR,
    input  Write_IR, Write_PC, PC_s, Write_Reg, rd_s, Write_PSR,
           ALU_OP, alu_src, Write_Res, undef
  );
endinterface

// File: rtl/branch_ctrl_decode.sv
// Combinational instruction classifier for the control FSM.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module branch_ctrl_decode
  import branch_ctrl_pkg::*;
(
  input  logic [28:5] ir,       // ir[k+1] = ARM bit k
  output logic        is_dp,
  output logic        is_test,
  output logic        is_b,
  output logic        is_bl,
  output logic        is_bx,
  output logic        is_undef
);

  // Classify: BX wins over DP since its encoding lives inside the DP space.
  always_comb begin
    is_bx    = (ir[28:5] == BX_PATTERN);
    is_dp    = (ir[28:27] == 2'b00) && !is_bx;
    is_test  = is_dp && (ir[25:24] == TEST_OP_MASK);
    is_b     = (ir[28:26] == 3'b101) && !ir[25];
    is_bl    = (ir[28:26] == 3'b101) && ir[25];
    is_undef = !(is_bx || is_dp || is_b || is_bl);
  end

endmodule

// File: rtl/branch_ctrl.sv
// Multicycle control FSM sequencing DP, B/BL and BX; optional perf counters under BRANCH_CTRL_PERF_EN.
// Latency: DP 4 cycles, B/BL/BX 3 cycles, condition-failed or undefined 2 cycles.
// Backpressure: none; fixed Moore sequence, Rst forces all outputs low and abandons the instruction.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter bit PSR_ON_S = 1'b1,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              Rst,
  branch_ctrl_if.master     bif
`ifdef BRANCH_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] retired,
  output logic [PERF_W-1:0] skipped,
  output logic [PERF_W-1:0] taken
`endif
);

  state_t state_q, state_d;
  logic   cond_ok_q, cond_ok_d;
  logic   undef_q, undef_d;

  logic is_dp, is_test, is_b, is_bl, is_bx, is_undef;

  // Low IR bits carry register numbers the controller never looks at.
  logic unused_ir;
  assign unused_ir = ^bif.IR[4:1];

  branch_ctrl_decode u_decode (
    .ir       (bif.IR[28:5]),
    .is_dp    (is_dp),
    .is_test  (is_test),
    .is_b     (is_b),
    .is_bl    (is_bl),
    .is_bx    (is_bx),
    .is_undef (is_undef)
  );

  // State, captured condition pass and sticky undef flag.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= S_FETCH;
      cond_ok_q <= 1'b0;
      undef_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cond_ok_q <= cond_ok_d;
      undef_q   <= undef_d;
    end
  end

  // Next-state: condition-failed decode skips straight back to fetch.
  always_comb begin
    state_d   = S_FETCH;
    cond_ok_d = cond_ok_q;
    undef_d   = undef_q;
    unique case (state_q)
      S_FETCH: begin
        cond_ok_d = bif.flag;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_ok_q)          state_d = S_FETCH;
        else if (is_bx)          state_d = S_BX;
        else if (is_b || is_bl)  state_d = S_BRANCH;
        else if (is_dp)          state_d = S_EXEC;
        else if (is_undef) begin
          undef_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_BX:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore outputs decoded from the state register, all held low during reset.
  always_comb begin
    bif.Write_IR  = 1'b0;
    bif.Write_PC  = 1'b0;
    bif.PC_s      = PCS_INC;
    bif.Write_Reg = 1'b0;
    bif.rd_s      = 1'b0;
    bif.Write_PSR = 1'b0;
    bif.ALU_OP    = 4'h0;
    bif.alu_src   = 1'b0;
    bif.Write_Res = 1'b0;
    bif.undef     = undef_q & ~Rst;
    if (!Rst) begin
      unique case (state_q)
        S_FETCH: begin
          bif.Write_IR = 1'b1;
          bif.Write_PC = 1'b1;
          bif.PC_s     = PCS_INC;
        end
        S_EXEC: begin
          bif.ALU_OP    = bif.IR[25:22];
          bif.alu_src   = bif.IR[26];
          bif.Write_Res = 1'b1;
        end
        S_WB: begin
          bif.ALU_OP    = bif.IR[25:22];
          bif.alu_src   = bif.IR[26];
          bif.Write_Reg = !is_test;
          bif.Write_PSR = is_test || bif.IR[21] || !PSR_ON_S;
        end
        S_BRANCH: begin
          // LR receives the PC already advanced during fetch.
          bif.Write_PC  = 1'b1;
          bif.PC_s      = PCS_B;
          bif.Write_Reg = is_bl;
          bif.rd_s      = is_bl;
        end
        S_BX: begin
          bif.Write_PC = 1'b1;
          bif.PC_s     = PCS_REG;
        end
        default: ;
      endcase
    end
  end

`ifdef BRANCH_CTRL_PERF_EN
  logic [PERF_W-1:0] retired_q, retired_d;
  logic [PERF_W-1:0] skipped_q, skipped_d;
  logic [PERF_W-1:0] taken_q, taken_d;

  // Counter increments: retire on leaving a final state, skip on failed condition.
  always_comb begin
    retired_d = retired_q;
    skipped_d = skipped_q;
    taken_d   = taken_q;
    if (state_q == S_WB || state_q == S_BRANCH || state_q == S_BX)
      retired_d = retired_q + PERF_W'(1);
    if (state_q == S_DECODE && !cond_ok_q)
      skipped_d = skipped_q + PERF_W'(1);
    if (state_q == S_BRANCH || state_q == S_BX)
      taken_d = taken_q + PERF_W'(1);
  end

  // Wrapping performance counters.
  always_ff @(posedge clk) begin
    if (Rst) begin
      retired_q <= '0;
      skipped_q <= '0;
      taken_q   <= '0;
    end else begin
      retired_q <= retired_d;
      skipped_q <= skipped_d;
      taken_q   <= taken_d;
    end
  end

  assign retired = Rst ? '0 : retired_q;
  assign skipped = Rst ? '0 : skipped_q;
  assign taken   = Rst ? '0 : taken_q;
`else
  localparam int UNUSED_PERF_W = PERF_W;
`endif

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Multicycle control FSM for the branch-capable CPU.
- It is the other end of the fetch/branch datapath interface: it consumes `flag` (condition pass) and `IR[28:1]` from the fetch unit.
- It drives `Write_IR`, `Write_PC` and `PC_s` back to the fetch unit, plus register-file, PSR and ALU-path controls.
- It sequences data-processing, B/BL and BX instructions, and skips condition-failed instructions.

Parameters:
- PSR_ON_S, 1, 1: non-test data-processing ops write the PSR only when the S bit is set; 0: always write the PSR.
- PERF_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- Rst  in  1  synchronous, active-high reset.
- flag  in  1  condition-code pass from the fetch unit; valid during S_FETCH.
- IR  in  28  latched instruction bits; IR[k+1] = ARM bit k. Valid from S_DECODE on.
- Write_IR  out  1  load IR.
- Write_PC  out  1  update PC.
- PC_s  out  2  PC source: 00 = PC+4, 01 = branch target (B), 10 = register (F, for BX).
- Write_Reg  out  1  register-file write enable.
- rd_s  out  1  destination select: 0 = Rd, 1 = LR (R14).
- Write_PSR  out  1  NZCV update enable.
- ALU_OP  out  4  ALU opcode, equal to IR[25:22] in S_EXEC.
- alu_src  out  1  0 = register operand, 1 = immediate (IR[26]).
- Write_Res  out  1  latch the ALU result register.
- undef  out  1  sticky; set on an unrecognised instruction, cleared only by Rst.

Behaviour:
- Outputs are Moore, decoded from the state register.
- While Rst=1 every output is forced to 0, and undef is cleared.
- Rst sets state to S_FETCH on the next posedge. A reset mid-instruction abandons it; no partial writes follow.
- Decode of IR:
  - BX: IR[28:5] == 24'h12FFF1.
  - DP: IR[28:27] == 00 and not BX.
  - B/BL: IR[28:26] == 101; the link bit is IR[25].
  - Anything else is undefined.
  - DP ops with opcode 10xx (TST/TEQ/CMP/CMN) are test ops.
- States and transitions:
  - S_FETCH: Write_IR=1, Write_PC=1, PC_s=00. Capture flag into cond_ok. Go to S_DECODE.
  - S_DECODE: all outputs 0.
    - cond_ok=0 → S_FETCH. The IR was not reloaded, so the instruction is skipped.
    - Else BX → S_BX; B/BL → S_BRANCH; DP → S_EXEC.
    - Else set undef and go to S_FETCH.
  - S_EXEC: ALU_OP=IR[25:22], alu_src=IR[26], Write_Res=1 → S_WB.
  - S_WB: ALU_OP and alu_src held.
    - Write_Reg=1 unless a test op; rd_s=0.
    - Write_PSR=1 if a test op, or IR[21]=1, or PSR_ON_S=0.
    - → S_FETCH.
  - S_BRANCH: Write_PC=1, PC_s=01. If IR[25]=1 also Write_Reg=1, rd_s=1 (LR gets the already-incremented PC). → S_FETCH.
  - S_BX: Write_PC=1, PC_s=10. → S_FETCH.
- Latency:
  - DP: 4 cycles.
  - B, BL, BX: 3 cycles.
  - Skipped or undefined: 2 cycles.
- PC_s=11 is never driven.
- At most one of {Write_Reg in S_WB, Write_PC in S_BRANCH or S_BX} pattern per state. BL asserting Write_PC and Write_Reg together in S_BRANCH is legal.
- An illegal state encoding recovers to S_FETCH with outputs 0.

Optional Feature:
- Macro BRANCH_CTRL_PERF_EN.
- Defined: adds outputs `retired[PERF_W-1:0]`, `skipped[PERF_W-1:0]` and `taken[PERF_W-1:0]`.
  - `retired` increments on leaving S_WB, S_BRANCH or S_BX.
  - `skipped` increments on the S_DECODE → S_FETCH transition with cond_ok=0.
  - `taken` increments in S_BRANCH and S_BX.
  - All counters wrap modulo 2^PERF_W and reset to 0 on Rst.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package branch_ctrl_pkg holds:
  - the state enum (S_FETCH, S_DECODE, S_EXEC, S_WB, S_BRANCH, S_BX);
  - PC_s constants (PCS_INC, PCS_B, PCS_REG);
  - the BX pattern 24'h12FFF1;
  - the test-op opcode mask 2'b10.
- Sub-module branch_ctrl_decode: combinational IR classifier with outputs is_dp, is_test, is_b, is_bl, is_bx, is_undef.

Test Plan:
- Reset then release; flag=1; IR = ADD r1,r2,r3 (ARM 0xE0821003 → IR[28:1] = 28'h0821003).
  - Expect one cycle each of S_FETCH (Write_IR=1, Write_PC=1, PC_s=00), S_DECODE, S_EXEC, then S_WB (ALU_OP=4'b0100, Write_Reg=1, Write_PSR=0).
- CMP (IR[25:22]=1010, IR[21]=1).
  - Expect S_WB with Write_Reg=0 and Write_PSR=1.
- BL (IR[28:25]=4'b1011), flag=1.
  - Expect S_BRANCH with Write_PC=1, PC_s=01, Write_Reg=1, rd_s=1; back in S_FETCH 3 cycles after the first fetch.
- BX (IR[28:5]=24'h12FFF1).
  - Expect PC_s=10 with Write_PC=1, and Write_Reg=0.
- flag=0 during S_FETCH with a branch in IR.
  - Expect S_DECODE → S_FETCH, no Write_PC in that decode cycle, and skipped+1 when the macro is defined.
- Assert Rst during S_EXEC.
  - Expect all outputs 0 that cycle, S_FETCH next, and no Write_Reg pulse.
- IR = 28'hC000000 (undefined class).
  - Expect undef=1, held until Rst.
